// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller: blank code,
// FSM state encoding and the BCD-to-segment decoder (active-low {g,f,e,d,c,b,a}).
package seg7_scan_ctrl_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  // Non-BCD nibbles decode to blank so the pins never see X.
  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_prescaler.sv
// Digit-slot prescaler: counts 0..REFRESH_DIV-1 and wraps; oTick marks the last
// count of a slot. iClr holds the count at zero.
module scan_prescaler #(
  parameter int CNT_W       = 17,
  parameter int REFRESH_DIV = 100000
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iClr,
  output logic oTick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign oTick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (iClr || oTick) cnt_d = '0;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller with a one-cycle dark
// gap between digits. Define SEG7_LZ_BLANK_EN to blank leading-zero digits.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iEn,
  input  logic                  iLoad,
  input  logic [4*DIGITS-1:0]   iData,
  input  logic [DIGITS-1:0]     iDp,
  output logic [6:0]            oSeg,
  output logic                  oDp,
  output logic [DIGITS-1:0]     oAn
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*DIGITS-1:0]   shd_data_q, shd_data_d;
  logic [DIGITS-1:0]     shd_dp_q, shd_dp_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  tick;
  logic                  pre_clr;
  logic [6:0]            seg_sel;

`ifdef SEG7_LZ_BLANK_EN
  // Digit k>0 is a leading zero when it and every higher nibble are zero.
  function automatic logic lz_blank(input logic [4*DIGITS-1:0] data,
                                    input logic [IDX_W-1:0]    idx);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (k >= 32'(idx) && data[4*k +: 4] != 4'd0) upper_zero = 1'b0;
    end
    return (idx != '0) && upper_zero;
  endfunction

  always_comb begin
    seg_sel = seg_decode(shd_data_q[4*idx_q +: 4]);
    if (lz_blank(shd_data_q, idx_q)) seg_sel = SEG_BLANK;
  end
`else
  always_comb seg_sel = seg_decode(shd_data_q[4*idx_q +: 4]);
`endif

  assign pre_clr = (state_q == ST_IDLE) || !iEn;

  scan_prescaler #(
    .CNT_W       (CNT_W),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_prescaler (
    .iClk  (iClk),
    .iRst  (iRst),
    .iClr  (pre_clr),
    .oTick (tick)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shd_data_d = shd_data_q;
    shd_dp_d   = shd_dp_q;
    seg_d      = seg_q;
    dp_d       = dp_q;
    an_d       = an_q;

    // Loads are independent of the FSM; the pins only pick them up on GAP->SCAN.
    if (iLoad) begin
      shd_data_d = iData;
      shd_dp_d   = iDp;
    end

    if (!iEn) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      seg_d   = SEG_BLANK;
      dp_d    = 1'b1;
      an_d    = '1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_GAP;
          idx_d   = '0;
          seg_d   = SEG_BLANK;
          dp_d    = 1'b1;
          an_d    = '1;
        end
        ST_GAP: begin
          state_d = ST_SCAN;
          seg_d   = seg_sel;
          dp_d    = ~shd_dp_q[idx_q];
          an_d    = ~(DIGITS'(1) << idx_q);
        end
        ST_SCAN: begin
          if (tick) begin
            state_d = ST_GAP;
            idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            seg_d   = SEG_BLANK;
            dp_d    = 1'b1;
            an_d    = '1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          seg_d   = SEG_BLANK;
          dp_d    = 1'b1;
          an_d    = '1;
        end
      endcase
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      shd_data_q <= '0;
      shd_dp_q   <= '0;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
      an_q       <= '1;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shd_data_q <= shd_data_d;
      shd_dp_q   <= shd_dp_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end

  assign oSeg = seg_q;
  assign oDp  = dp_q;
  assign oAn  = an_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIGITS=4, REFRESH_DIV=4.
// Expectations track SEG7_LZ_BLANK_EN when the bench is built with it.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dpi = '0;
  logic [6:0]  seg;
  logic        dpo;
  logic [3:0]  an;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .DIGITS      (4),
    .REFRESH_DIV (4),
    .CNT_W       (3)
  ) dut (
    .iClk  (clk),
    .iRst  (rst),
    .iEn   (en),
    .iLoad (load),
    .iData (data),
    .iDp   (dpi),
    .oSeg  (seg),
    .oDp   (dpo),
    .oAn   (an)
  );

  localparam logic [6:0] SB = 7'h7F;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
`ifdef SEG7_LZ_BLANK_EN
  localparam logic [6:0] SZ = SB;
`else
  localparam logic [6:0] SZ = S0;
`endif

  typedef struct {
    logic        en;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        odp;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic e, input logic l, input logic [15:0] d,
                     input logic [3:0] p, input logic [3:0] a,
                     input logic [6:0] s, input logic o);
    vec_t v;
    v.en = e; v.load = l; v.data = d; v.dp = p;
    v.an = a; v.seg = s; v.odp = o;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] a,
                       input logic [6:0] s, input logic o);
    checks++;
    if ({an, seg, dpo} !== {a, s, o}) begin
      errors++;
      $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
               name, an, seg, dpo, a, s, o);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Frame for 16'h1234 with DP on digit 2: 1 dark + 3 lit cycles per slot.
    add(1, 1, 16'h1234, 4'b0100, 4'hF, SB, 1);
    for (int k = 0; k < 3; k++) add(1, 0, 16'h1234, 4'b0100, 4'b1110, S4, 1);
    add(1, 0, 16'h1234, 4'b0100, 4'hF, SB, 1);
    for (int k = 0; k < 3; k++) add(1, 0, 16'h1234, 4'b0100, 4'b1101, S3, 1);
    add(1, 0, 16'h1234, 4'b0100, 4'hF, SB, 1);
    for (int k = 0; k < 3; k++) add(1, 0, 16'h1234, 4'b0100, 4'b1011, S2, 0);
    add(1, 0, 16'h1234, 4'b0100, 4'hF, SB, 1);
    for (int k = 0; k < 3; k++) add(1, 0, 16'h1234, 4'b0100, 4'b0111, S1, 1);
    add(1, 0, 16'h1234, 4'b0100, 4'hF, SB, 1);
    add(1, 0, 16'h1234, 4'b0100, 4'b1110, S4, 1);

    #12;
    check("reset_state", 4'hF, SB, 1);
    rst = 1'b0;
    step(2);
    check("idle_no_en", 4'hF, SB, 1);

    foreach (tbl[i]) begin
      en   = tbl[i].en;
      load = tbl[i].load;
      data = tbl[i].data;
      dpi  = tbl[i].dp;
      step(1);
      check($sformatf("vec%0d", i), tbl[i].an, tbl[i].seg, tbl[i].odp);
    end
    load = 1'b0;

    // Disable during digit 2, loading at the same time; re-enable.
    step(8);
    check("dig2_before_disable", 4'b1011, S2, 0);
    en = 1'b0; load = 1'b1; data = 16'h00A7; dpi = 4'b0000;
    step(1);
    check("disable_dark", 4'hF, SB, 1);
    load = 1'b0;
    step(1);
    check("idle_hold", 4'hF, SB, 1);
    en = 1'b1;
    step(1);
    check("reenable_gap", 4'hF, SB, 1);
    step(1);
    check("reenable_dig0", 4'b1110, S7, 1);
    step(4);
    check("nibble_a_blank", 4'b1101, SB, 1);
    step(4);
    check("dig2_zero", 4'b1011, SZ, 1);
    step(4);
    check("dig3_zero", 4'b0111, SZ, 1);
    step(4);
    check("dig0_again", 4'b1110, S7, 1);
    step(4);
    check("dig1_lit", 4'b1101, SB, 1);

    // Load mid-slot: digit 1 keeps old code, digit 2 shows the new one.
    load = 1'b1; data = 16'h5555;
    step(1);
    check("midslot_hold_a", 4'b1101, SB, 1);
    load = 1'b0;
    step(1);
    check("midslot_hold_b", 4'b1101, SB, 1);
    step(1);
    check("slot_gap", 4'hF, SB, 1);
    step(1);
    check("dig2_new", 4'b1011, S5, 1);

    // Asynchronous reset while lit, well away from any clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 4'hF, SB, 1);
    en = 1'b0;
    step(2);
    rst = 1'b0;
    step(3);
    check("post_rst_dark", 4'hF, SB, 1);

    // Load on the GAP cycle: current slot uses old (reset) shadow data.
    en = 1'b1;
    step(1);
    check("restart_gap", 4'hF, SB, 1);
    load = 1'b1; data = 16'h0009;
    step(1);
    check("gap_load_ignored", 4'b1110, S0, 1);
    load = 1'b0;
    step(4);
    check("dig1_after_load", 4'b1101, SZ, 1);
    step(12);
    check("gap_load_used", 4'b1110, S9, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got simulation still running, expected finish");
    $fatal(1);
  end

endmodule
